// File: rtl/knn_vote_if.sv
// -----------------------------------------------------------------------------
// knn_vote_if
//   Bundles the request/result signals between a k-NN neighbour-list producer
//   (or software driver) and the knn_vote majority-vote block.
//
//   Signals
//     start          request a vote (only honoured while the voter is idle)
//     neighbour_info packed labels, slot i = [i*LABEL +: LABEL], slot 0 nearest
//     n_valid        number of filled slots counted from slot 0
//     busy           voter is not idle
//     done           one-cycle pulse, class_out/vote_count valid
//     class_out      winning label
//     vote_count     occurrences of the winning label among the valid slots
//
//   Modports
//     master : drives the request, observes the result
//     slave  : the voter itself
// -----------------------------------------------------------------------------
interface knn_vote_if #(
  parameter int LABEL       = 8,
  parameter int N_NEIGHBOUR = 10,
  parameter int CNT_W       = $clog2(N_NEIGHBOUR + 1)
);
  logic                         start;
  logic [LABEL*N_NEIGHBOUR-1:0] neighbour_info;
  logic [CNT_W-1:0]             n_valid;
  logic                         busy;
  logic                         done;
  logic [LABEL-1:0]             class_out;
  logic [CNT_W-1:0]             vote_count;

  modport master (
    output start, neighbour_info, n_valid,
    input  busy, done, class_out, vote_count
  );

  modport slave (
    input  start, neighbour_info, n_valid,
    output busy, done, class_out, vote_count
  );
endinterface

// File: rtl/knn_vote.sv
// -----------------------------------------------------------------------------
// knn_vote
//   Majority vote over the k-nearest-neighbour label list. On start (while
//   idle) the label list and the clamped fill count are snapshotted; the block
//   then visits one slot per cycle, counts how many valid slots carry the same
//   label, and keeps the first label reaching the highest count (ties therefore
//   go to the nearer neighbour). The result is registered on entry to DONE and
//   flagged by a one-cycle done pulse; it holds until the next vote or reset.
//
//   Ports
//     clk  : clock, rising edge
//     rst  : asynchronous reset, active low
//     bus  : knn_vote_if.slave (start, neighbour_info, n_valid in;
//            busy, done, class_out, vote_count out)
//
//   Latency: done arrives n+1 cycles after the start cycle, n = min(n_valid, k).
// -----------------------------------------------------------------------------
module knn_vote #(
  parameter int LABEL       = 8,
  parameter int N_NEIGHBOUR = 10,
  parameter int CNT_W       = $clog2(N_NEIGHBOUR + 1)
) (
  input  logic       clk,
  input  logic       rst,
  knn_vote_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Snapshot of the request, frozen for the whole vote
  logic [LABEL-1:0] snap [N_NEIGHBOUR];
  logic [CNT_W-1:0] n_reg;

  // Scan position and running best
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] best_cnt;
  logic [LABEL-1:0] best_lbl;

  // Registered result
  logic [LABEL-1:0] class_q;
  logic [CNT_W-1:0] vote_q;

  // Combinational helpers
  logic [CNT_W-1:0] n_in;
  logic [LABEL-1:0] cur_lbl;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] best_cnt_nxt;
  logic [LABEL-1:0] best_lbl_nxt;
  logic             last_slot;

  // Saturate the requested fill count at the list length.
  function automatic logic [CNT_W-1:0] clamp_n(input logic [CNT_W-1:0] v);
    if (v > CNT_W'(N_NEIGHBOUR)) begin
      return CNT_W'(N_NEIGHBOUR);
    end
    return v;
  endfunction

  assign n_in      = clamp_n(bus.n_valid);
  assign last_slot = (idx == n_reg - CNT_W'(1));

  // Slot under examination; an explicit mux keeps the select inside the array
  // even though idx is wider than needed to address N_NEIGHBOUR entries.
  always_comb begin
    cur_lbl = '0;
    for (int j = 0; j < N_NEIGHBOUR; j++) begin
      if (idx == CNT_W'(j)) begin
        cur_lbl = snap[j];
      end
    end
  end

  // N_NEIGHBOUR parallel equality comparators, masked to the valid slots.
  always_comb begin
    match_cnt = '0;
    for (int j = 0; j < N_NEIGHBOUR; j++) begin
      if ((CNT_W'(j) < n_reg) && (snap[j] == cur_lbl)) begin
        match_cnt = match_cnt + CNT_W'(1);
      end
    end
  end

  // Strictly-greater update: an equal count never displaces an earlier slot,
  // which is what makes ties resolve toward the nearest neighbour.
  always_comb begin
    best_cnt_nxt = best_cnt;
    best_lbl_nxt = best_lbl;
    if (match_cnt > best_cnt) begin
      best_cnt_nxt = match_cnt;
      best_lbl_nxt = cur_lbl;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = (n_in != '0) ? COUNT : DONE;
        end
      end
      COUNT: begin
        if (last_slot) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: snapshot, scan and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < N_NEIGHBOUR; j++) begin
        snap[j] <= '0;
      end
      n_reg    <= '0;
      idx      <= '0;
      best_cnt <= '0;
      best_lbl <= '0;
      class_q  <= '0;
      vote_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            for (int j = 0; j < N_NEIGHBOUR; j++) begin
              snap[j] <= bus.neighbour_info[j*LABEL +: LABEL];
            end
            n_reg    <= n_in;
            idx      <= '0;
            best_cnt <= '0;
            best_lbl <= '0;
            // Empty list goes straight to DONE with a zero result.
            if (n_in == '0) begin
              class_q <= '0;
              vote_q  <= '0;
            end
          end
        end
        COUNT: begin
          idx      <= idx + CNT_W'(1);
          best_cnt <= best_cnt_nxt;
          best_lbl <= best_lbl_nxt;
          // Load the result from the updated best so the final slot counts.
          if (last_slot) begin
            class_q <= best_lbl_nxt;
            vote_q  <= best_cnt_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.class_out  = class_q;
  assign bus.vote_count = vote_q;

endmodule
